// File: rtl/axi_phase_diff.sv
// Phase differentiator for the FM/PM demod chain.
// Takes {mag, phase} beats and emits {mag, dphase}. dphase is the modulo-2^WIDTH
// difference between consecutive phase samples. A magnitude squelch forces
// dphase to zero, and a saturating counter records how many beats were squelched.
//
// state | meaning
// ------+--------------------------------------------------------------
// FIRST | no phase history yet; the next accepted beat emits dphase = 0
// RUN   | prev_phase is valid; dphase = phase - prev_phase
module axi_phase_diff #(
  parameter int WIDTH         = 16,
  parameter int RESET_ON_LAST = 1,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic [2*WIDTH-1:0]     i_tdata,
  input  logic                   i_tlast,
  input  logic                   i_tvalid,
  output logic                   i_tready,
  output logic [2*WIDTH-1:0]     o_tdata,
  output logic                   o_tlast,
  output logic                   o_tvalid,
  input  logic                   o_tready,
  input  logic [WIDTH-1:0]       squelch_thresh,
  output logic [CNT_WIDTH-1:0]   squelch_cnt,
  input  logic                   cnt_clear
);

  localparam bit CLEAR_ON_LAST = (RESET_ON_LAST != 0);

  typedef enum logic {
    FIRST = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [WIDTH-1:0]   prev_phase;
  logic [WIDTH-1:0]   in_mag;
  logic [WIDTH-1:0]   in_phase;
  logic [WIDTH:0]     diff_full;
  logic [WIDTH-1:0]   dphase;
  logic               xfer;
  logic               squelched;
  logic               cnt_full;

  assign in_mag    = i_tdata[2*WIDTH-1:WIDTH];
  assign in_phase  = i_tdata[WIDTH-1:0];

  // The output register can take a new beat if it is empty or is being drained.
  assign i_tready  = ~o_tvalid | o_tready;
  assign xfer      = i_tvalid & i_tready;

  // One extra bit on the subtraction; dropping it gives the natural +pi/-pi wrap.
  assign diff_full = {1'b0, in_phase} - {1'b0, prev_phase};

  assign squelched = (squelch_thresh != '0) && (in_mag < squelch_thresh);
  assign cnt_full  = &squelch_cnt;

  // Next-state and dphase selection; squelch only masks the output value.
  always_comb begin
    state_d = state_q;
    dphase  = '0;
    case (state_q)
      FIRST: begin
        dphase = '0;
        if (xfer) begin
          if (i_tlast && CLEAR_ON_LAST) state_d = FIRST;
          else                          state_d = RUN;
        end
      end
      RUN: begin
        dphase = diff_full[WIDTH-1:0];
        if (xfer && i_tlast && CLEAR_ON_LAST) state_d = FIRST;
      end
      default: begin
        state_d = FIRST;
        dphase  = '0;
      end
    endcase
    if (squelched) dphase = '0;
  end

  // State register and phase history; both advance only on an accepted beat.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= FIRST;
      prev_phase <= '0;
    end else if (xfer) begin
      state_q    <= state_d;
      prev_phase <= in_phase;
    end
  end

  // Single output register stage; holds its contents while stalled downstream.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      o_tvalid <= 1'b0;
      o_tdata  <= '0;
      o_tlast  <= 1'b0;
    end else if (xfer) begin
      o_tvalid <= 1'b1;
      o_tdata  <= {in_mag, dphase};
      o_tlast  <= i_tlast;
    end else if (o_tready) begin
      o_tvalid <= 1'b0;
    end
  end

  // Saturating squelch counter; a clear wins over a same-cycle increment.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      squelch_cnt <= '0;
    end else if (cnt_clear) begin
      squelch_cnt <= '0;
    end else if (xfer && squelched && !cnt_full) begin
      squelch_cnt <= squelch_cnt + 1'b1;
    end
  end

endmodule
